// File: rtl/rf_write_arbiter.sv
// Shares the register-file write port between WB (priority) and buffered MDU
// results, with WAW kill, pending-register mask and a starvation stall.
module rf_write_arbiter #(
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wb_we,
  input  logic [4:0]  wb_waddr,
  input  logic [31:0] wb_wd,
  input  logic        mdu_valid,
  output logic        mdu_ready,
  input  logic [4:0]  mdu_waddr,
  input  logic [31:0] mdu_wd,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wd,
  output logic [31:0] busy_mask,
  output logic        stall_req
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [PW-1:0] PTR_ONE    = PW'(1);
  localparam logic [SW-1:0] STARVE_ONE = SW'(1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
  localparam logic [CW-1:0] CNT_FULL   = CW'(DEPTH);

  logic [DEPTH-1:0] live_q, live_d;
  logic [4:0]       addr_q [DEPTH];
  logic [31:0]      data_q [DEPTH];
  logic [PW-1:0]    rptr_q, rptr_d, wptr_q, wptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [SW-1:0]    starve_q, starve_d;
  logic             rf_we_q, rf_we_d;
  logic [4:0]       rf_waddr_q, rf_waddr_d;
  logic [31:0]      rf_wd_q, rf_wd_d;

  logic        full_s, empty_s, wb_req_s, pop_s, push_s;
  logic [31:0] busy_s;

  assign full_s    = (cnt_q == CNT_FULL);
  assign empty_s   = (cnt_q == {CW{1'b0}});
  assign stall_req = (starve_q == STARVE_MAX);
  assign mdu_ready = !full_s && !rst;
  // A stalled cycle masks WB entirely, so the head wins whenever WB is not asking.
  assign wb_req_s  = wb_we && (wb_waddr != 5'd0) && !stall_req;
  assign pop_s     = !empty_s && !wb_req_s;
  assign push_s    = mdu_valid && mdu_ready;

  assign rf_we     = rf_we_q;
  assign rf_waddr  = rf_waddr_q;
  assign rf_wd     = rf_wd_q;
  assign busy_mask = {busy_s[31:1], 1'b0};

  // Pending-register mask built from live buffer entries only.
  always_comb begin
    busy_s = 32'd0;
    for (int i = 0; i < DEPTH; i++) begin
      busy_s = busy_s | (live_q[i] ? (32'd1 << addr_q[i]) : 32'd0);
    end
  end

  // Next-state for buffer bookkeeping, starvation counter and write port.
  always_comb begin
    live_d = live_q;
    for (int i = 0; i < DEPTH; i++) begin
      // The slot being pushed is free, so a same-edge WB kill never touches it.
      if (push_s && (wptr_q == PW'(i))) begin
        live_d[i] = (mdu_waddr != 5'd0);
      end else begin
        live_d[i] = live_q[i]
                    && !(wb_req_s && (addr_q[i] == wb_waddr))
                    && !(pop_s && (rptr_q == PW'(i)));
      end
    end

    rptr_d = pop_s  ? (rptr_q + PTR_ONE) : rptr_q;
    wptr_d = push_s ? (wptr_q + PTR_ONE) : wptr_q;
    cnt_d  = cnt_q + CW'(push_s) - CW'(pop_s);

    if (pop_s || empty_s) begin
      starve_d = {SW{1'b0}};
    end else if (wb_req_s && (starve_q != STARVE_MAX)) begin
      starve_d = starve_q + STARVE_ONE;
    end else begin
      starve_d = starve_q;
    end

    if (pop_s) begin
      rf_we_d    = live_q[rptr_q];
      rf_waddr_d = live_q[rptr_q] ? addr_q[rptr_q] : rf_waddr_q;
      rf_wd_d    = live_q[rptr_q] ? data_q[rptr_q] : rf_wd_q;
    end else if (wb_req_s) begin
      rf_we_d    = 1'b1;
      rf_waddr_d = wb_waddr;
      rf_wd_d    = wb_wd;
    end else begin
      rf_we_d    = 1'b0;
      rf_waddr_d = rf_waddr_q;
      rf_wd_d    = rf_wd_q;
    end
  end

  // State registers with synchronous reset that discards all buffered results.
  always_ff @(posedge clk) begin
    if (rst) begin
      live_q     <= {DEPTH{1'b0}};
      rptr_q     <= {PW{1'b0}};
      wptr_q     <= {PW{1'b0}};
      cnt_q      <= {CW{1'b0}};
      starve_q   <= {SW{1'b0}};
      rf_we_q    <= 1'b0;
      rf_waddr_q <= 5'd0;
      rf_wd_q    <= 32'd0;
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= 5'd0;
        data_q[i] <= 32'd0;
      end
    end else begin
      live_q     <= live_d;
      rptr_q     <= rptr_d;
      wptr_q     <= wptr_d;
      cnt_q      <= cnt_d;
      starve_q   <= starve_d;
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wd_q    <= rf_wd_d;
      if (push_s) begin
        addr_q[wptr_q] <= mdu_waddr;
        data_q[wptr_q] <= mdu_wd;
      end
    end
  end
endmodule

// File: tb/tb_rf_write_arbiter.sv
// Bench for rf_write_arbiter: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_rf_write_arbiter;
  localparam int DEPTH = 2;
  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        wb_we;
  logic [4:0]  wb_waddr;
  logic [31:0] wb_wd;
  logic        mdu_valid;
  logic        mdu_ready;
  logic [4:0]  mdu_waddr;
  logic [31:0] mdu_wd;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wd;
  logic [31:0] busy_mask;
  logic        stall_req;

  rf_write_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst),
    .wb_we(wb_we), .wb_waddr(wb_waddr), .wb_wd(wb_wd),
    .mdu_valid(mdu_valid), .mdu_ready(mdu_ready),
    .mdu_waddr(mdu_waddr), .mdu_wd(mdu_wd),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wd(rf_wd),
    .busy_mask(busy_mask), .stall_req(stall_req)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit        live;
    bit [4:0]  a;
    bit [31:0] d;
  } ent_t;

  ent_t      q[$];
  int        starve;
  bit        m_we;
  bit [4:0]  m_addr;
  bit [31:0] m_wd;
  bit        model_ok = 1'b0;
  int        checks = 0;
  int        errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: pending results are a plain queue; outputs compared each negedge.
  initial begin
    ent_t      h;
    bit        ready_e, stall_e, wbreq, push;
    bit [31:0] busy_e;
    forever begin
      @(negedge clk);
      ready_e = (q.size() < DEPTH) && !rst;
      stall_e = (starve == LIMIT);
      busy_e  = 32'd0;
      foreach (q[i]) if (q[i].live) busy_e[q[i].a] = 1'b1;
      if (model_ok) begin
        chk("mdu_ready", 32'(mdu_ready), 32'(ready_e));
        chk("stall_req", 32'(stall_req), 32'(stall_e));
        chk("busy_mask", busy_mask, busy_e);
        chk("rf_we", 32'(rf_we), 32'(m_we));
        chk("rf_waddr", 32'(rf_waddr), 32'(m_addr));
        chk("rf_wd", rf_wd, m_wd);
      end
      if (rst) begin
        q.delete();
        starve   = 0;
        m_we     = 1'b0;
        m_addr   = 5'd0;
        m_wd     = 32'd0;
        model_ok = 1'b1;
      end else begin
        wbreq = wb_we && (wb_waddr != 5'd0) && !stall_e;
        push  = mdu_valid && ready_e;
        if (!wbreq && q.size() > 0) begin
          h      = q.pop_front();
          m_we   = h.live;
          if (h.live) begin
            m_addr = h.a;
            m_wd   = h.d;
          end
          starve = 0;
        end else if (wbreq) begin
          m_we   = 1'b1;
          m_addr = wb_waddr;
          m_wd   = wb_wd;
          foreach (q[i]) if (q[i].live && q[i].a == wb_waddr) q[i].live = 1'b0;
          starve = (q.size() > 0) ? ((starve < LIMIT) ? starve + 1 : LIMIT) : 0;
        end else begin
          m_we   = 1'b0;
          starve = 0;
        end
        if (push) begin
          h.live = (mdu_waddr != 5'd0);
          h.a    = mdu_waddr;
          h.d    = mdu_wd;
          q.push_back(h);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wb(input logic we, input logic [4:0] a, input logic [31:0] d);
    wb_we = we; wb_waddr = a; wb_wd = d;
  endtask

  task automatic mdu(input logic v, input logic [4:0] a, input logic [31:0] d);
    mdu_valid = v; mdu_waddr = a; mdu_wd = d;
  endtask

  initial begin
    bit hold;
    rst = 1'b1;
    wb(1'b0, 5'd0, 32'd0);
    mdu(1'b1, 5'd9, 32'h5555_5555);
    tick(); tick();
    chk("rst_ready", 32'(mdu_ready), 32'd0);
    chk("rst_rf_we", 32'(rf_we), 32'd0);
    chk("rst_busy", busy_mask, 32'd0);
    rst = 1'b0;
    mdu(1'b0, 5'd0, 32'd0);
    #1;
    chk("post_rst_ready", 32'(mdu_ready), 32'd1);
    tick();

    // Idle drain
    mdu(1'b1, 5'd5, 32'hDEAD_BEEF); tick();
    mdu(1'b0, 5'd0, 32'd0);
    chk("drain_busy", busy_mask, 32'h0000_0020);
    chk("drain_we0", 32'(rf_we), 32'd0);
    tick();
    chk("drain_we", 32'(rf_we), 32'd1);
    chk("drain_addr", 32'(rf_waddr), 32'd5);
    chk("drain_wd", rf_wd, 32'hDEAD_BEEF);
    chk("drain_busy_clr", busy_mask, 32'd0);
    tick();

    // x0 suppression and dead-entry consumption
    wb(1'b1, 5'd0, 32'h99); mdu(1'b1, 5'd0, 32'h77); tick();
    chk("x0_we", 32'(rf_we), 32'd0);
    chk("x0_busy", busy_mask, 32'd0);
    wb(1'b0, 5'd0, 32'd0); mdu(1'b1, 5'd3, 32'h33); tick();
    chk("x0_dead_pop", 32'(rf_we), 32'd0);
    chk("x0_busy3", busy_mask, 32'h0000_0008);
    mdu(1'b0, 5'd0, 32'd0); tick();
    chk("x0_next_we", 32'(rf_we), 32'd1);
    chk("x0_next_addr", 32'(rf_waddr), 32'd3);
    chk("x0_next_wd", rf_wd, 32'h33);

    // WAW kill
    mdu(1'b1, 5'd7, 32'h11); tick();
    chk("waw_busy", busy_mask, 32'h0000_0080);
    wb(1'b1, 5'd7, 32'h22); mdu(1'b0, 5'd0, 32'd0); tick();
    chk("waw_wb_we", 32'(rf_we), 32'd1);
    chk("waw_wb_wd", rf_wd, 32'h22);
    chk("waw_busy_clr", busy_mask, 32'd0);
    wb(1'b0, 5'd0, 32'd0); tick();
    chk("waw_dead_pop", 32'(rf_we), 32'd0);
    chk("waw_wd_hold", rf_wd, 32'h22);
    tick();

    // Priority, full buffer and starvation stall
    wb(1'b1, 5'd1, 32'h101); mdu(1'b1, 5'd10, 32'hA0A0); tick();
    chk("prio_addr1", 32'(rf_waddr), 32'd1);
    chk("prio_busy1", busy_mask, 32'h0000_0400);
    wb(1'b1, 5'd2, 32'h102); mdu(1'b1, 5'd11, 32'hB0B0); tick();
    chk("full_ready", 32'(mdu_ready), 32'd0);
    chk("prio_addr2", 32'(rf_waddr), 32'd2);
    chk("prio_busy2", busy_mask, 32'h0000_0C00);
    wb(1'b1, 5'd3, 32'h103); mdu(1'b0, 5'd0, 32'd0); tick();
    chk("prio_addr3", 32'(rf_waddr), 32'd3);
    wb(1'b1, 5'd4, 32'h104); tick();
    chk("starve_no_stall", 32'(stall_req), 32'd0);
    chk("prio_addr4", 32'(rf_waddr), 32'd4);
    wb(1'b1, 5'd5, 32'h105); tick();
    chk("starve_stall", 32'(stall_req), 32'd1);
    chk("prio_addr5", 32'(rf_waddr), 32'd5);
    wb(1'b1, 5'd6, 32'h106); tick();
    chk("forced_we", 32'(rf_we), 32'd1);
    chk("forced_addr", 32'(rf_waddr), 32'd10);
    chk("forced_wd", rf_wd, 32'hA0A0);
    chk("stall_drop", 32'(stall_req), 32'd0);
    chk("ready_again", 32'(mdu_ready), 32'd1);
    tick();
    chk("held_wb_addr", 32'(rf_waddr), 32'd6);
    chk("held_wb_wd", rf_wd, 32'h106);
    wb(1'b0, 5'd0, 32'd0); tick();
    chk("tail_addr", 32'(rf_waddr), 32'd11);
    chk("tail_wd", rf_wd, 32'hB0B0);
    tick();

    // Reset mid-drain discards the buffered result
    mdu(1'b1, 5'd12, 32'hC0C0); tick();
    chk("mid_busy", busy_mask, 32'h0000_1000);
    rst = 1'b1; mdu(1'b0, 5'd0, 32'd0); tick();
    chk("mid_rst_we", 32'(rf_we), 32'd0);
    chk("mid_rst_busy", busy_mask, 32'd0);
    chk("mid_rst_ready", 32'(mdu_ready), 32'd0);
    rst = 1'b0; tick();
    chk("mid_no_write", 32'(rf_we), 32'd0);

    // Randomized traffic; WB re-presents its request after a stall cycle
    hold = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      if (!hold) begin
        wb_we    = ($urandom_range(0, 9) < 7);
        wb_waddr = 5'($urandom_range(0, 7));
        wb_wd    = $urandom;
      end
      mdu_valid = 1'($urandom_range(0, 1));
      mdu_waddr = 5'($urandom_range(0, 7));
      mdu_wd    = $urandom;
      rst       = ($urandom_range(0, 499) == 0);
      hold      = (starve == LIMIT) && !rst;
      tick();
    end
    rst = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/rf_write_arbiter.md
# rf_write_arbiter

Shares the single register-file write port between the WB stage and the multi-cycle MUL/DIV unit (MDU) of the RV32IM pipeline. WB writes have priority. MDU results are accepted through a valid/ready handshake and buffered in a small FIFO until the port is free. The block suppresses writes to x0, resolves WAW against buffered MDU results, exports a pending-register mask for hazard detection, and raises a pipeline stall when MDU results starve.

## Interface
- DEPTH, 2, MDU result buffer entries (power of two, ≥2)
- STARVE_LIMIT, 4, consecutive starved cycles before stall_req asserts (≥1)
- clk  in  1  posedge clock for all state (the register file itself samples on negedge)
- rst  in  1  reset: synchronous, active-high
- wb_we  in  1  WB stage write request
- wb_waddr  in  5  WB destination register
- wb_wd  in  32  WB write data
- mdu_valid  in  1  MDU result valid
- mdu_ready  out  1  buffer can accept; = !full && !rst
- mdu_waddr  in  5  MDU destination register
- mdu_wd  in  32  MDU result
- rf_we  out  1  register-file write enable (registered)
- rf_waddr  out  5  register-file write address (registered)
- rf_wd  out  32  register-file write data (registered)
- busy_mask  out  32  bit i = 1 when a live buffered MDU entry targets xi; bit 0 always 0
- stall_req  out  1  pipeline must hold WB; = (starve_cnt == STARVE_LIMIT)

## Operation
- Buffer: circular FIFO of DEPTH entries {live, waddr, wd}, with read/write pointers and a count of width clog2(DEPTH)+1.
  - Push on posedge when mdu_valid && mdu_ready.
  - A pushed entry is stored live only if mdu_waddr != 0; otherwise it is stored dead.
- WB effective request: wb_req = wb_we && wb_waddr != 0 && !stall_req.
- Grant per cycle, decided combinationally and registered at the posedge:
  - stall_req=1: grant the head; WB inputs are ignored for that cycle (no write, no kill).
  - else if wb_req: grant WB → rf_we=1, rf_waddr/rf_wd from WB.
  - else if buffer non-empty: pop the head. A live head gives rf_we=1 with its addr/data. A dead head gives rf_we=0 and still consumes the cycle.
  - else: rf_we=0; rf_waddr/rf_wd hold their previous values.
- WAW kill: when WB is granted, every live buffered entry whose waddr == wb_waddr is marked dead on the same edge. A push that occurs on that same edge is not killed.
- Starve counter (saturating at STARVE_LIMIT):
  - Increments each cycle the buffer is non-empty and WB is granted.
  - Clears on any pop or when the buffer is empty.
  - Holds otherwise.
- Full and pop on the same edge: mdu_ready was already 0, so no push. There is no same-cycle refill.
- Empty and push on the same edge: the entry is not grantable until the next cycle (no bypass).
- Pointers wrap modulo DEPTH.
- Reset: buffer emptied and all entries marked dead; starve_cnt=0; rf_we=0, rf_waddr=0, rf_wd=0; busy_mask=0; stall_req=0; mdu_ready=0 while rst=1 and 1 after. Reset mid-drain discards buffered results with no write.

## Timing
- WB write: presented in cycle N → rf_we high in cycle N+1; the register file commits at the negedge of N+1.
- MDU result: accepted at edge N → earliest rf_we in cycle N+2 (granted in N+1, registered at its end).
- mdu_ready and busy_mask are combinational from registered state only. There is no combinational path from mdu_valid, wb_*.
- stall_req is high for exactly the cycle in which the head is force-granted. It drops in the following cycle, because starve_cnt clears on the pop.
- Pipeline contract: while stall_req=1, WB holds wb_* stable and re-presents them the next cycle.

## Test plan
- Reset: hold rst for 2 cycles with mdu_valid=1 → mdu_ready=0, rf_we=0, busy_mask=0. After release, mdu_ready=1.
- Idle drain: push MDU {x5, 0xDEADBEEF} at edge 1 with wb_we=0 → busy_mask[5]=1 in cycle 2; rf_we=1, rf_waddr=5, rf_wd=0xDEADBEEF in cycle 3; busy_mask=0 after.
- Priority/full: wb_we=1 continuously (x1..x9); push 2 MDU results → mdu_ready=0 after the second push; no MDU write while WB is granted.
- Starvation: with the buffer non-empty and WB writing every cycle, stall_req asserts after 4 starved cycles (STARVE_LIMIT=4). The head writes that cycle and WB is ignored. stall_req drops the next cycle, and the held WB write then commits.
- WAW kill: buffer holds {x7, 0x11}; WB writes x7=0x22 → rf_wd=0x22. The head later pops with rf_we=0, and busy_mask[7] clears on the WB grant edge.
- x0: MDU push to x0 and WB write to x0 → no rf_we; busy_mask[0] stays 0. The dead entry pops and consumes one cycle.
